// File: rtl/aliens_bus_ctrl_if.sv
// Main-CPU bus handshake and palette arbitration signals for aliens_bus_ctrl.
//   cs_n      : active-low decoded chip selects (from address decode)
//   cpu_req   : CPU access request, held until cpu_ack
//   cpu_ack   : one-cycle access-complete pulse
//   cpu_mrdy  : memory ready, low while the CPU is stalled
//   region    : latched index of the selected chip select
//   vid_req   : video palette read request (level)
//   vid_grant : video owns the palette this cycle
//   pal_sel   : palette address mux select (1 = video), mirrors vid_grant
interface aliens_bus_ctrl_if;
  logic [7:0] cs_n;
  logic       cpu_req;
  logic       cpu_ack;
  logic       cpu_mrdy;
  logic [2:0] region;
  logic       vid_req;
  logic       vid_grant;
  logic       pal_sel;

  // Controller side
  modport slave (
    input  cs_n, cpu_req, vid_req,
    output cpu_ack, cpu_mrdy, region, vid_grant, pal_sel
  );

  // CPU / video requester side
  modport master (
    output cs_n, cpu_req, vid_req,
    input  cpu_ack, cpu_mrdy, region, vid_grant, pal_sel
  );
endinterface

// File: rtl/aliens_bus_ctrl.sv
// Aliens main-CPU bus access controller: per-region wait-state insertion,
// CPU ready/acknowledge generation and palette RAM arbitration between the
// CPU and video scanout.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : aliens_bus_ctrl_if.slave (chip selects, CPU handshake, video
//             palette request/grant, palette mux select)
module aliens_bus_ctrl #(
  parameter int unsigned WS_ROM        = 1,
  parameter int unsigned WS_IO         = 2,
  parameter int unsigned WS_PAL        = 1,
  parameter int unsigned WS_RAM        = 0,
  parameter int unsigned VID_BURST_MAX = 4
) (
  input logic              clk,
  input logic              reset_n,
  aliens_bus_ctrl_if.slave bus
);

  localparam int unsigned WS_MAX_A = (WS_ROM > WS_IO) ? WS_ROM : WS_IO;
  localparam int unsigned WS_MAX_B = (WS_PAL > WS_RAM) ? WS_PAL : WS_RAM;
  localparam int unsigned WS_MAX   = (WS_MAX_A > WS_MAX_B) ? WS_MAX_A : WS_MAX_B;
  localparam int unsigned CW       = (WS_MAX == 0) ? 1 : $clog2(WS_MAX + 1);
  localparam int unsigned BW       = (VID_BURST_MAX == 0) ? 1 : $clog2(VID_BURST_MAX + 1);
  localparam logic [2:0]  PAL_REGION = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    CPU_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    region_q, region_d;
  logic          pal_q, pal_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          grant_q, grant_d;
  logic          ack_q;
  logic          mrdy_q;

  logic [2:0]    sel_idx;
  logic          sel_any;
  logic [CW-1:0] ws_sel;
  logic          cpu_pal_pending;
  logic          cpu_owns;

  // Lowest-index active chip select wins; open bus reads as region 0
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!bus.cs_n[i]) begin
        sel_idx = 3'(i);
        sel_any = 1'b1;
      end
    end
  end

  // Wait-state count for the selected region
  always_comb begin
    ws_sel = '0;
    if (sel_any) begin
      case (sel_idx)
        3'd0, 3'd1:             ws_sel = CW'(WS_ROM);
        3'd2, 3'd3, 3'd4, 3'd5: ws_sel = CW'(WS_IO);
        3'd6:                   ws_sel = CW'(WS_PAL);
        default:                ws_sel = CW'(WS_RAM);
      endcase
    end
  end

  assign cpu_pal_pending = (state_q == CPU_WAIT) && pal_q;
  // Palette waits only advance in cycles where the CPU has the palette
  assign cpu_owns        = !pal_q || !grant_q;

  // Access FSM and palette arbiter next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    pal_d    = pal_q;
    grant_d  = 1'b0;
    burst_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          region_d = sel_idx;
          pal_d    = sel_any && (sel_idx == PAL_REGION);
          cnt_d    = ws_sel;
          state_d  = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        if (!bus.cpu_req) begin
          state_d = IDLE;
        end else if (cpu_owns) begin
          if (cnt_q == '0) state_d = CPU_DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      CPU_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Video is capped only while a CPU palette access is waiting
    grant_d = bus.vid_req && !(cpu_pal_pending && (burst_q == BW'(VID_BURST_MAX)));
    if (cpu_pal_pending && grant_d) begin
      burst_d = (burst_q == BW'(VID_BURST_MAX)) ? burst_q : burst_q + BW'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      region_q <= '0;
      pal_q    <= 1'b0;
      burst_q  <= '0;
      grant_q  <= 1'b0;
      ack_q    <= 1'b0;
      mrdy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      pal_q    <= pal_d;
      burst_q  <= burst_d;
      grant_q  <= grant_d;
      // Handshake outputs follow the FSM state by one cycle
      ack_q    <= (state_q == CPU_DONE);
      mrdy_q   <= (state_q != CPU_WAIT);
    end
  end

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_mrdy  = mrdy_q;
  assign bus.region    = region_q;
  assign bus.vid_grant = grant_q;
  assign bus.pal_sel   = grant_q;

endmodule

// File: tb/tb_aliens_bus_ctrl.sv
// Directed self-checking bench for aliens_bus_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge; "cycle N+i" is the period
// after rising edge N+i, where edge N samples the new cpu_req.
module tb_aliens_bus_ctrl;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  aliens_bus_ctrl_if bus ();

  aliens_bus_ctrl #(
    .WS_ROM        (1),
    .WS_IO         (2),
    .WS_PAL        (1),
    .WS_RAM        (0),
    .VID_BURST_MAX (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One CPU access: request sampled at edge N, ack expected in cycle N+ack_off,
  // mrdy low in cycles N+1 .. N+ack_off-1. vid_exp bit i is the grant in cycle N+i.
  task automatic run_access(input string name, input logic [7:0] cs, input int ack_off,
                            input logic [2:0] reg_exp, input bit chk_vid,
                            input logic [15:0] vid_exp);
    @(negedge clk);
    bus.cs_n    = cs;
    bus.cpu_req = 1'b1;
    for (int i = 0; i <= ack_off + 2; i++) begin
      @(negedge clk);
      chk($sformatf("%s mrdy c%0d", name, i), 32'(bus.cpu_mrdy),
          (i >= 1 && i < ack_off) ? 32'd0 : 32'd1);
      chk($sformatf("%s ack c%0d", name, i), 32'(bus.cpu_ack),
          (i == ack_off) ? 32'd1 : 32'd0);
      chk($sformatf("%s region c%0d", name, i), 32'(bus.region), 32'(reg_exp));
      if (chk_vid && i < 16) begin
        chk($sformatf("%s grant c%0d", name, i), 32'(bus.vid_grant), 32'(vid_exp[i]));
        chk($sformatf("%s pal_sel c%0d", name, i), 32'(bus.pal_sel), 32'(vid_exp[i]));
      end
      if (i == ack_off) begin
        bus.cpu_req = 1'b0;
        bus.cs_n    = 8'hFF;
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.cs_n    = 8'hFF;
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;

    // Reset held with inputs toggling
    repeat (4) begin
      @(negedge clk);
      bus.cs_n    = 8'($urandom);
      bus.cpu_req = ~bus.cpu_req;
      bus.vid_req = ~bus.vid_req;
      #1;
      chk("rst mrdy", 32'(bus.cpu_mrdy), 32'd1);
      chk("rst ack", 32'(bus.cpu_ack), 32'd0);
      chk("rst grant", 32'(bus.vid_grant), 32'd0);
      chk("rst pal_sel", 32'(bus.pal_sel), 32'd0);
      chk("rst region", 32'(bus.region), 32'd0);
    end
    @(negedge clk);
    bus.cs_n    = 8'hFF;
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    reset_n     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post-rst mrdy", 32'(bus.cpu_mrdy), 32'd1);
      chk("post-rst ack", 32'(bus.cpu_ack), 32'd0);
      chk("post-rst grant", 32'(bus.vid_grant), 32'd0);
    end

    // Per-region wait states, priority and open bus
    run_access("io2",   8'b1111_1011, 4, 3'd2, 1'b1, 16'h0000);
    run_access("prio",  8'b0111_1100, 3, 3'd0, 1'b0, 16'h0000);
    run_access("open",  8'hFF,        2, 3'd0, 1'b0, 16'h0000);
    run_access("rom1",  8'b1111_1101, 3, 3'd1, 1'b0, 16'h0000);
    run_access("ram",   8'b0111_1111, 2, 3'd7, 1'b0, 16'h0000);
    run_access("io5",   8'b1101_1111, 4, 3'd5, 1'b0, 16'h0000);

    // Palette contention with video streaming: burst cap of 4 under pending
    // CPU access, CPU-owned cycles at c5 and c10, ack in c12, grants resume c11
    @(negedge clk);
    bus.vid_req = 1'b1;
    repeat (3) @(negedge clk);
    run_access("pal", 8'b1011_1111, 12, 3'd6, 1'b1, 16'hFBDF);
    bus.vid_req = 1'b0;
    repeat (2) @(negedge clk);

    // Palette access without video contention behaves like WS_PAL waits
    run_access("pal-free", 8'b1011_1111, 3, 3'd6, 1'b1, 16'h0000);

    // Abort: cpu_req dropped in cycle N+1 of an I/O access
    @(negedge clk);
    bus.cs_n    = 8'b1111_1011;
    bus.cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort mrdy c1", 32'(bus.cpu_mrdy), 32'd0);
    bus.cpu_req = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("abort ack c%0d", i), 32'(bus.cpu_ack), 32'd0);
      chk($sformatf("abort mrdy c%0d", i), 32'(bus.cpu_mrdy), (i == 2) ? 32'd0 : 32'd1);
    end

    // Asynchronous reset during CPU_WAIT
    @(negedge clk);
    bus.cs_n    = 8'b1111_1011;
    bus.cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid mrdy before", 32'(bus.cpu_mrdy), 32'd0);
    chk("rstmid region before", 32'(bus.region), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid mrdy", 32'(bus.cpu_mrdy), 32'd1);
    chk("rstmid ack", 32'(bus.cpu_ack), 32'd0);
    chk("rstmid region", 32'(bus.region), 32'd0);
    chk("rstmid grant", 32'(bus.vid_grant), 32'd0);
    bus.cpu_req = 1'b0;
    bus.cs_n    = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid ack after c%0d", i), 32'(bus.cpu_ack), 32'd0);
      chk($sformatf("rstmid mrdy after c%0d", i), 32'(bus.cpu_mrdy), 32'd1);
    end

    // Video alone: 20 requested cycles, no burst limit
    @(negedge clk);
    bus.vid_req = 1'b1;
    for (int i = 0; i <= 21; i++) begin
      @(negedge clk);
      chk($sformatf("vid grant c%0d", i), 32'(bus.vid_grant), (i < 20) ? 32'd1 : 32'd0);
      chk($sformatf("vid pal_sel c%0d", i), 32'(bus.pal_sel), (i < 20) ? 32'd1 : 32'd0);
      if (i == 19) bus.vid_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
